// File: rtl/rmt_axis_pkg.sv
// Shared types and helpers for the AXI-Stream sink/statistics monitor.
// Ready-pattern modes, LFSR constants, FSM states and tkeep helpers.
package rmt_axis_pkg;

   localparam logic [1:0] READY_MODE_ALWAYS = 2'd0;
   localparam logic [1:0] READY_MODE_ALT    = 2'd1;
   localparam logic [1:0] READY_MODE_LFSR   = 2'd2;
   localparam logic [1:0] READY_MODE_NEVER  = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // taps 16,14,13,11 as state bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int KEEP_MAX = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IN_PKT,
      ST_DROP
   } state_e;

   function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] k);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < KEEP_MAX; i++) begin
         n = n + {7'd0, k[i]};
      end
      return n;
   endfunction

   function automatic logic keep_contiguous(input logic [KEEP_MAX-1:0] k);
      return (k & (k + {{(KEEP_MAX-1){1'b0}}, 1'b1})) == '0;
   endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// Backpressure pattern generator: mode mux, toggle flop and LFSR,
// producing a registered tready.
module axis_ready_gen
   import rmt_axis_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] ready_mode,
   output logic       tready
);

   logic [15:0] lfsr_q, lfsr_d;
   logic        toggle_q, toggle_d;
   logic        tready_q, tready_d;

   always_comb begin
      lfsr_d   = lfsr_q;
      toggle_d = toggle_q;
      tready_d = 1'b0;
      if (enable) begin
         lfsr_d   = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
         toggle_d = ~toggle_q;
         case (ready_mode)
            READY_MODE_ALWAYS: tready_d = 1'b1;
            READY_MODE_ALT:    tready_d = toggle_q;
            READY_MODE_LFSR:   tready_d = lfsr_d[0];
            default:           tready_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q   <= LFSR_SEED;
         toggle_q <= 1'b1;
         tready_q <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         toggle_q <= toggle_d;
         tready_q <= tready_d;
      end
   end

   assign tready = tready_q;

endmodule

// File: rtl/axis_pkt_sink_stats.sv
// AXI-Stream sink with programmable backpressure; counts packets,
// beats, bytes, framing errors and captures the last packet header.
module axis_pkt_sink_stats
   import rmt_axis_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int CNT_WIDTH            = 64,
   parameter int MAX_BEATS            = 64
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic [1:0]                        ready_mode,
   input  logic                              clear_stats,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [CNT_WIDTH-1:0]              pkt_cnt,
   output logic [CNT_WIDTH-1:0]              beat_cnt,
   output logic [CNT_WIDTH-1:0]              byte_cnt,
   output logic [CNT_WIDTH-1:0]              err_cnt,
   output logic [CNT_WIDTH-1:0]              cycle_cnt,
   output logic [CNT_WIDTH-1:0]              stall_cnt,
   output logic [127:0]                      first_hdr,
   output logic [15:0]                       last_pkt_len,
   output logic                              in_pkt
);

   localparam int KW     = C_S_AXIS_DATA_WIDTH / 8;
   localparam int BW     = $clog2(KW) + 1;
   localparam int BEAT_W = $clog2(MAX_BEATS + 2);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [BEAT_W-1:0]     beats_q, beats_d, beats_inc;
   logic [15:0]           len_q, len_d, len_new, len_base;
   logic [16:0]           len_sum;
   logic                  err_q, err_d, err_new, keep_err;
   logic [127:0]          shdr_q, shdr_d, hdr_src;
   logic [CNT_WIDTH-1:0]  pkt_q, pkt_d, beat_q, beat_d, byte_q, byte_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d, cyc_q, cyc_d, stall_q, stall_d;
   logic [127:0]          first_hdr_q, first_hdr_d;
   logic [15:0]           last_len_q, last_len_d;
   logic                  in_pkt_q, in_pkt_d;
   logic                  hs, done, is_idle;
   logic [BW-1:0]         beat_bytes;
   logic [KEEP_MAX-1:0]   keep_ext;
   logic                  unused_ok;

   axis_ready_gen u_ready (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .ready_mode (ready_mode),
      .tready     (s_axis_tready)
   );

   assign unused_ok  = ^{s_axis_tuser, s_axis_tdata[C_S_AXIS_DATA_WIDTH-1:128]};
   assign hs         = s_axis_tvalid & s_axis_tready;
   assign is_idle    = (state_q == ST_IDLE);
   assign keep_ext   = KEEP_MAX'(s_axis_tkeep);
   assign beat_bytes = BW'(popcount(keep_ext));

   always_comb begin
      keep_err = 1'b0;
      if (s_axis_tlast)
         keep_err = (s_axis_tkeep == '0) || !keep_contiguous(keep_ext);
      else
         keep_err = (s_axis_tkeep != '1);
   end

   // first beat of a packet starts the accumulators from zero
   assign len_base  = is_idle ? 16'd0 : len_q;
   assign len_sum   = {1'b0, len_base} + 17'(beat_bytes);
   assign len_new   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
   assign err_new   = (!is_idle && err_q) || keep_err;
   assign hdr_src   = is_idle ? s_axis_tdata[127:0] : shdr_q;
   assign beats_inc = beats_q + BEAT_W'(1);

   always_comb begin
      state_d = state_q;
      beats_d = beats_q;
      len_d   = len_q;
      err_d   = err_q;
      shdr_d  = shdr_q;
      done    = 1'b0;
      if (hs) begin
         len_d = len_new;
         err_d = err_new;
         case (state_q)
            ST_IDLE: begin
               shdr_d  = s_axis_tdata[127:0];
               beats_d = BEAT_W'(1);
               if (s_axis_tlast) done = 1'b1;
               else state_d = ST_IN_PKT;
            end
            ST_IN_PKT: begin
               beats_d = beats_inc;
               if (s_axis_tlast) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end else if (beats_inc > BEAT_W'(MAX_BEATS)) begin
                  err_d   = 1'b1;
                  state_d = ST_DROP;
               end
            end
            ST_DROP: begin
               if (s_axis_tlast) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      in_pkt_d = (state_d != ST_IDLE);
   end

   always_comb begin
      pkt_d       = pkt_q;
      beat_d      = beat_q;
      byte_d      = byte_q;
      err_cnt_d   = err_cnt_q;
      cyc_d       = cyc_q;
      stall_d     = stall_q;
      first_hdr_d = first_hdr_q;
      last_len_d  = last_len_q;
      if (clear_stats) begin
         pkt_d       = '0;
         beat_d      = '0;
         byte_d      = '0;
         err_cnt_d   = '0;
         cyc_d       = '0;
         stall_d     = '0;
         first_hdr_d = '0;
         last_len_d  = '0;
      end else begin
         if (enable) cyc_d = cyc_q + CNT_ONE;
         if (s_axis_tvalid && !s_axis_tready) stall_d = stall_q + CNT_ONE;
         if (hs) begin
            beat_d = beat_q + CNT_ONE;
            byte_d = byte_q + CNT_WIDTH'(beat_bytes);
         end
         if (done) begin
            pkt_d       = pkt_q + CNT_ONE;
            first_hdr_d = hdr_src;
            last_len_d  = len_new;
            if (err_new) err_cnt_d = err_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beats_q     <= '0;
         len_q       <= '0;
         err_q       <= 1'b0;
         shdr_q      <= '0;
         pkt_q       <= '0;
         beat_q      <= '0;
         byte_q      <= '0;
         err_cnt_q   <= '0;
         cyc_q       <= '0;
         stall_q     <= '0;
         first_hdr_q <= '0;
         last_len_q  <= '0;
         in_pkt_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         len_q       <= len_d;
         err_q       <= err_d;
         shdr_q      <= shdr_d;
         pkt_q       <= pkt_d;
         beat_q      <= beat_d;
         byte_q      <= byte_d;
         err_cnt_q   <= err_cnt_d;
         cyc_q       <= cyc_d;
         stall_q     <= stall_d;
         first_hdr_q <= first_hdr_d;
         last_len_q  <= last_len_d;
         in_pkt_q    <= in_pkt_d;
      end
   end

   assign pkt_cnt      = pkt_q;
   assign beat_cnt     = beat_q;
   assign byte_cnt     = byte_q;
   assign err_cnt      = err_cnt_q;
   assign cycle_cnt    = cyc_q;
   assign stall_cnt    = stall_q;
   assign first_hdr    = first_hdr_q;
   assign last_pkt_len = last_len_q;
   assign in_pkt       = in_pkt_q;

endmodule

// File: tb/tb_axis_pkt_sink_stats.sv
// Bench for axis_pkt_sink_stats: directed scenarios plus random traffic
// compared every cycle against a packet-level reference model.
module tb_axis_pkt_sink_stats;

   localparam int DW   = 512;
   localparam int KW   = DW / 8;
   localparam int TUW  = 128;
   localparam int CW   = 64;
   localparam int MAXB = 4;
   localparam logic [KW-1:0] FULL = '1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b1, enable = 1'b0, clear_stats = 1'b0;
   logic [1:0]     ready_mode = 2'd0;
   logic [DW-1:0]  tdata = '0;
   logic [KW-1:0]  tkeep = '0;
   logic [TUW-1:0] tuser = '0;
   logic           tvalid = 1'b0, tlast = 1'b0;
   logic           tready, in_pkt;
   logic [CW-1:0]  pkt_cnt, beat_cnt, byte_cnt, err_cnt, cycle_cnt, stall_cnt;
   logic [127:0]   first_hdr;
   logic [15:0]    last_pkt_len;

   axis_pkt_sink_stats #(
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_TUSER_WIDTH (TUW),
      .CNT_WIDTH            (CW),
      .MAX_BEATS            (MAXB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .ready_mode    (ready_mode),
      .clear_stats   (clear_stats),
      .s_axis_tdata  (tdata),
      .s_axis_tkeep  (tkeep),
      .s_axis_tuser  (tuser),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .s_axis_tlast  (tlast),
      .pkt_cnt       (pkt_cnt),
      .beat_cnt      (beat_cnt),
      .byte_cnt      (byte_cnt),
      .err_cnt       (err_cnt),
      .cycle_cnt     (cycle_cnt),
      .stall_cnt     (stall_cnt),
      .first_hdr     (first_hdr),
      .last_pkt_len  (last_pkt_len),
      .in_pkt        (in_pkt)
   );

   int n_chk = 0;
   int n_fail = 0;
   int n_steps = 0;

   // reference model state
   logic [CW-1:0] m_pkt, m_beat, m_byte, m_err, m_cyc, m_stall;
   logic [127:0]  m_hdr, cur_hdr;
   logic [15:0]   m_len, m_lfsr;
   int            cur_beats, cur_len;
   bit            cur_err, m_ready, m_hs;
   int unsigned   m_k;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic bit keep_bad(input logic [KW-1:0] k, input logic last);
      int n;
      logic [KW-1:0] prefix;
      n = $countones(k);
      if (!last) return k != FULL;
      if (n == 0) return 1'b1;
      prefix = (n == KW) ? FULL : ((64'd1 << n) - 64'd1);
      return k != prefix;
   endfunction

   task automatic model_edge();
      int nb;
      bit done;
      done = 1'b0;
      if (rst) begin
         m_pkt = '0; m_beat = '0; m_byte = '0; m_err = '0;
         m_cyc = '0; m_stall = '0; m_hdr = '0; m_len = '0;
         cur_beats = 0; m_ready = 1'b0; m_hs = 1'b0;
         m_k = 0; m_lfsr = 16'hACE1;
         return;
      end
      m_hs = tvalid && m_ready;
      nb = $countones(tkeep);
      if (m_hs) begin
         if (cur_beats == 0) begin
            cur_hdr = tdata[127:0];
            cur_len = 0;
            cur_err = 1'b0;
         end
         cur_beats++;
         cur_len += nb;
         if (keep_bad(tkeep, tlast)) cur_err = 1'b1;
         if (cur_beats > MAXB && !tlast) cur_err = 1'b1;
         if (tlast) begin
            done = 1'b1;
            cur_beats = 0;
         end
      end
      if (clear_stats) begin
         m_pkt = '0; m_beat = '0; m_byte = '0; m_err = '0;
         m_cyc = '0; m_stall = '0; m_hdr = '0; m_len = '0;
      end else begin
         if (enable) m_cyc++;
         if (tvalid && !m_ready) m_stall++;
         if (m_hs) begin
            m_beat++;
            m_byte += CW'(nb);
         end
         if (done) begin
            m_pkt++;
            if (cur_err) m_err++;
            m_hdr = cur_hdr;
            m_len = (cur_len > 65535) ? 16'hFFFF : 16'(cur_len);
         end
      end
      if (enable) begin
         m_k++;
         m_lfsr = lfsr_next(m_lfsr);
      end
      m_ready = enable && ((ready_mode == 2'd0) ||
                           (ready_mode == 2'd1 && m_k[0]) ||
                           (ready_mode == 2'd2 && m_lfsr[0]));
   endtask

   task automatic compare_all();
      check("tready",    128'(tready),       128'(m_ready));
      check("pkt_cnt",   128'(pkt_cnt),      128'(m_pkt));
      check("beat_cnt",  128'(beat_cnt),     128'(m_beat));
      check("byte_cnt",  128'(byte_cnt),     128'(m_byte));
      check("err_cnt",   128'(err_cnt),      128'(m_err));
      check("cycle_cnt", 128'(cycle_cnt),    128'(m_cyc));
      check("stall_cnt", 128'(stall_cnt),    128'(m_stall));
      check("first_hdr", first_hdr,          m_hdr);
      check("pkt_len",   128'(last_pkt_len), 128'(m_len));
      check("in_pkt",    128'(in_pkt),       128'(cur_beats != 0));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      n_steps++;
      #1;
      compare_all();
   endtask

   task automatic rand_data();
      for (int i = 0; i < DW / 32; i++) tdata[i*32 +: 32] = $urandom();
   endtask

   function automatic logic [KW-1:0] rand_keep(input logic last);
      logic [KW-1:0] k;
      int n;
      k = FULL;
      if ($urandom_range(0, 4) == 0) begin
         k = {$urandom(), $urandom()};
         if (last && $urandom_range(0, 1) == 0) begin
            n = $urandom_range(0, KW - 1);
            k = (64'd1 << n) - 64'd1;
         end
      end
      return k;
   endfunction

   task automatic send_beat(input logic [127:0] hdr, input logic [KW-1:0] k,
                            input logic last);
      int i;
      rand_data();
      tdata[127:0] = hdr;
      tkeep  = k;
      tlast  = last;
      tvalid = 1'b1;
      for (i = 0; i < 100; i++) begin
         step();
         if (m_hs) break;
      end
      if (i == 100) check("hs_timeout", 128'd0, 128'd1);
   endtask

   task automatic idle(input int n);
      tvalid = 1'b0;
      tlast  = 1'b0;
      repeat (n) step();
   endtask

   task automatic clr();
      tvalid = 1'b0;
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
   endtask

   initial begin
      logic [CW-1:0] stall0;
      int steps0;

      rst = 1'b1; enable = 1'b1; ready_mode = 2'd0;
      step();
      check("rst_tready", 128'(tready), 128'd0);
      check("rst_pkt", 128'(pkt_cnt), 128'd0);
      check("rst_in_pkt", 128'(in_pkt), 128'd0);
      rst = 1'b0;
      step();
      check("tready_after_rst", 128'(tready), 128'd1);

      // single full beat
      clr();
      send_beat(128'h050000000000, FULL, 1'b1);
      idle(1);
      check("sb_pkt", 128'(pkt_cnt), 128'd1);
      check("sb_beat", 128'(beat_cnt), 128'd1);
      check("sb_byte", 128'(byte_cnt), 128'd64);
      check("sb_len", 128'(last_pkt_len), 128'd64);
      check("sb_hdr", first_hdr, 128'h050000000000);
      check("sb_err", 128'(err_cnt), 128'd0);

      // partial last beat
      clr();
      send_beat(128'h1111, FULL, 1'b0);
      send_beat(128'h2222, FULL, 1'b0);
      send_beat(128'h3333, 64'hFF, 1'b1);
      idle(1);
      check("part_byte", 128'(byte_cnt), 128'd136);
      check("part_len", 128'(last_pkt_len), 128'd136);
      check("part_err", 128'(err_cnt), 128'd0);
      check("part_hdr", first_hdr, 128'h1111);

      // non-contiguous last keep, then two bad mid beats in one packet
      clr();
      send_beat(128'hA, FULL, 1'b0);
      send_beat(128'hB, 64'h0F0F, 1'b1);
      idle(1);
      check("nc_err", 128'(err_cnt), 128'd1);
      check("nc_pkt", 128'(pkt_cnt), 128'd1);
      send_beat(128'hC, {{(KW-1){1'b1}}, 1'b0}, 1'b0);
      send_beat(128'hD, {{(KW-1){1'b1}}, 1'b0}, 1'b0);
      send_beat(128'hE, FULL, 1'b1);
      idle(1);
      check("mid_err", 128'(err_cnt), 128'd2);

      // alternate ready, tvalid held high
      clr();
      ready_mode = 2'd1;
      idle(2);
      for (int i = 0; i < 4 && m_ready; i++) step();
      stall0 = m_stall;
      steps0 = n_steps;
      for (int p = 0; p < 10; p++) send_beat(128'(p), FULL, 1'b1);
      check("alt_cycles", 128'(n_steps - steps0), 128'd20);
      check("alt_stall", 128'(stall_cnt), 128'(stall0 + 64'd10));
      idle(1);
      ready_mode = 2'd0;
      idle(2);

      // oversize: beat MAXB+1 without tlast
      clr();
      for (int b = 1; b <= 5; b++) send_beat(128'(b), FULL, 1'b0);
      check("ovs_in_pkt", 128'(in_pkt), 128'd1);
      check("ovs_err_pending", 128'(err_cnt), 128'd0);
      send_beat(128'd6, FULL, 1'b1);
      idle(1);
      check("ovs_err", 128'(err_cnt), 128'd1);
      check("ovs_beat", 128'(beat_cnt), 128'd6);
      check("ovs_pkt", 128'(pkt_cnt), 128'd1);
      check("ovs_hdr", first_hdr, 128'd1);

      // exactly MAXB+1 beats ending in tlast is legal
      clr();
      for (int b = 1; b <= 4; b++) send_beat(128'(b), FULL, 1'b0);
      send_beat(128'd5, FULL, 1'b1);
      idle(1);
      check("max1_err", 128'(err_cnt), 128'd0);
      check("max1_len", 128'(last_pkt_len), 128'd320);

      // reset mid-packet
      clr();
      send_beat(128'h77, FULL, 1'b0);
      send_beat(128'h78, FULL, 1'b0);
      tvalid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_in_pkt", 128'(in_pkt), 128'd0);
      send_beat(128'h99, FULL, 1'b0);
      send_beat(128'h9A, FULL, 1'b1);
      idle(1);
      check("rst_pkt_cnt", 128'(pkt_cnt), 128'd1);
      check("rst_beat_cnt", 128'(beat_cnt), 128'd2);
      check("rst_hdr", first_hdr, 128'h99);

      // clear coincident with a handshake
      tvalid = 1'b1; tlast = 1'b1; tkeep = FULL;
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      tvalid = 1'b0;
      check("clr_pkt", 128'(pkt_cnt), 128'd0);
      check("clr_beat", 128'(beat_cnt), 128'd0);
      check("clr_byte", 128'(byte_cnt), 128'd0);
      check("clr_cycle", 128'(cycle_cnt), 128'd0);
      check("clr_len", 128'(last_pkt_len), 128'd0);
      idle(2);

      // random traffic against the model
      ready_mode = 2'd2;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 399) == 0);
         clear_stats = ($urandom_range(0, 149) == 0);
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) ready_mode = 2'($urandom_range(0, 3));
         tvalid = ($urandom_range(0, 3) != 0);
         tlast = ($urandom_range(0, 3) == 0);
         rand_data();
         tkeep = rand_keep(tlast);
         tuser = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
